// File: rtl/key_led_pkg.sv
// Shared types and sizes for the key-to-LED round-robin arbiter.
package key_led_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
   localparam int NUM_KEYS = 8;
   localparam int ID_W     = 3;
endpackage

// File: rtl/key_led_arbiter_debouncer.sv
// One push-button channel: 2-flop synchronizer, debounce counter and a
// single-cycle pulse on each accepted press.
module key_debouncer
   import key_led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic key,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic          stable;
   logic          stable_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta     <= 1'b0;
         sync     <= 1'b0;
         stable   <= 1'b0;
         stable_q <= 1'b0;
         cnt      <= '0;
      end else begin
         meta     <= key;
         sync     <= meta;
         stable_q <= stable;
         if (sync != stable) begin
            // the cycle that would make the count reach DEBOUNCE_CYCLES commits the level
            if (cnt == CNT_LAST) begin
               stable <= sync;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise = stable & ~stable_q;
endmodule

// File: rtl/key_led_arbiter.sv
// Round-robin owner of the LED bank: debounced key presses queue requests,
// one winner at a time lights its LED for HOLD_CYCLES, then a blank cycle.
module key_led_arbiter
   import key_led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key,
   output logic [NUM_KEYS-1:0] led,
   output logic                grant_valid,
   output logic [ID_W-1:0]     grant_id
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   arb_state_t          state;
   logic [NUM_KEYS-1:0] rise;
   logic [NUM_KEYS-1:0] pending;
   logic [NUM_KEYS-1:0] clr_mask;
   logic [ID_W-1:0]     last;
   logic [ID_W-1:0]     winner;
   logic [ID_W-1:0]     idx;
   logic                found;
   logic [HW-1:0]       hold_cnt;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clock (clock),
         .reset (reset),
         .key   (key[i]),
         .rise  (rise[i])
      );
   end

   // Search from last+1 upward; the 3-bit add wraps modulo 8.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned i = 1; i <= NUM_KEYS; i++) begin
         idx = last + ID_W'(i);
         if (!found && pending[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      clr_mask = '0;
      if (state == IDLE && found) clr_mask = NUM_KEYS'(1) << winner;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pending     <= '0;
         last        <= '1;
         hold_cnt    <= '0;
         led         <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
      end else begin
         // a new press in the same cycle as its grant re-queues the key
         pending <= (pending & ~clr_mask) | rise;
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id    <= winner;
                  last        <= winner;
                  hold_cnt    <= HOLD_LAST;
                  led         <= NUM_KEYS'(1) << winner;
                  grant_valid <= 1'b1;
                  state       <= GRANT;
               end
            end
            GRANT: begin
               if (hold_cnt == '0) begin
                  led         <= '0;
                  grant_valid <= 1'b0;
                  state       <= GAP;
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
